// File: rtl/cvtb_pkt_buffer.sv
// Single-packet store-and-forward buffer: captures one packet, then either forwards it
// immediately or holds it for CPU inspection, editing, send or drop.
module cvtb_pkt_buffer #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH/8,
  parameter int ADDR_WIDTH    = 8,
  parameter int NUM_HDR_WORDS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  mode,
  input  logic [1:0]            cpu_sel,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  input  logic                  cpu_wen,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  pkt_held
);

  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int HDR_CNT_W = $clog2(NUM_HDR_WORDS + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;

  localparam logic [1:0] SEL_DATA = 2'b00;
  localparam logic [1:0] SEL_CTRL = 2'b01;
  localparam logic [1:0] SEL_TAIL = 2'b10;
  localparam logic [1:0] SEL_CMD  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;
  localparam logic [HDR_CNT_W-1:0]  HDR_ONE  = 1;
  localparam logic [HDR_CNT_W-1:0]  HDR_DONE = HDR_CNT_W'(NUM_HDR_WORDS);
  localparam logic [15:0]           CNT_MAX  = 16'hFFFF;

  logic [DATA_WIDTH-1:0] mem_data [0:DEPTH-1];
  logic [CTRL_WIDTH-1:0] mem_ctrl [0:DEPTH-1];

  logic [2:0]            state_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] tail_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [HDR_CNT_W-1:0]  hdr_cnt_reg;
  logic [15:0]           pkt_count_reg;
  logic [15:0]           drop_count_reg;
  logic                  rd_done_reg;
  logic                  rd_valid_reg;
  logic                  rd_last_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [CTRL_WIDTH-1:0] out_ctrl_reg;
  logic [DATA_WIDTH-1:0] cpu_dout_reg;

  logic                  in_ctrl_nz;
  logic                  ingress_we;
  logic [ADDR_WIDTH-1:0] ingress_addr;
  logic                  cpu_in_hold;
  logic                  cpu_data_we;
  logic                  cpu_ctrl_we;
  logic                  cpu_tail_we;
  logic                  cpu_cmd_we;
  logic                  drain_issue;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [HDR_CNT_W-1:0]  hdr_cnt_next;
  logic [15:0]           pkt_count_next;
  logic [15:0]           drop_count_next;
  logic [DATA_WIDTH-1:0] status_word;

  always_comb begin
    in_ctrl_nz = |in_ctrl;
    case (state_reg)
      S_HOLD, S_DRAIN: in_rdy = 1'b0;
      default:         in_rdy = 1'b1;
    endcase
    ingress_we = in_wr && (((state_reg == S_IDLE) && in_ctrl_nz) ||
                           (state_reg == S_HEADER) || (state_reg == S_PAYLOAD));
    ingress_addr = (state_reg == S_IDLE) ? '0 : wr_ptr_reg;

    cpu_in_hold = (state_reg == S_HOLD) && cpu_wen;
    cpu_data_we = cpu_in_hold && (cpu_sel == SEL_DATA);
    cpu_ctrl_we = cpu_in_hold && (cpu_sel == SEL_CTRL);
    cpu_tail_we = cpu_in_hold && (cpu_sel == SEL_TAIL);
    cpu_cmd_we  = cpu_in_hold && (cpu_sel == SEL_CMD);
    // Ingress and CPU writes never overlap: the CPU may only write while ingress is blocked.
    mem_waddr   = ingress_we ? ingress_addr : cpu_addr;

    // rd_done stops a re-issue once rd_ptr wraps past a tail at the top address.
    drain_issue = (state_reg == S_DRAIN) && out_rdy && !rd_done_reg &&
                  (rd_ptr_reg <= tail_ptr_reg);

    hdr_cnt_next    = hdr_cnt_reg + HDR_ONE;
    pkt_count_next  = (pkt_count_reg  == CNT_MAX) ? pkt_count_reg  : pkt_count_reg  + 16'd1;
    drop_count_next = (drop_count_reg == CNT_MAX) ? drop_count_reg : drop_count_reg + 16'd1;

    status_word                   = '0;
    status_word[2:0]              = state_reg;
    status_word[ADDR_WIDTH+2:3]   = tail_ptr_reg;
    status_word[47:32]            = pkt_count_reg;
    status_word[63:48]            = drop_count_reg;
  end

  always_ff @(posedge clk) begin
    if (ingress_we || cpu_data_we)
      mem_data[mem_waddr] <= ingress_we ? in_data : cpu_din;
    if (ingress_we || cpu_ctrl_we)
      mem_ctrl[mem_waddr] <= ingress_we ? in_ctrl : cpu_din[CTRL_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      wr_ptr_reg     <= '0;
      tail_ptr_reg   <= '0;
      rd_ptr_reg     <= '0;
      hdr_cnt_reg    <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
      rd_done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_wr && in_ctrl_nz) begin
            wr_ptr_reg  <= ADDR_ONE;
            hdr_cnt_reg <= '0;
            state_reg   <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (in_wr) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_ONE;
            if (wr_ptr_reg == ADDR_TOP) begin
              drop_count_reg <= drop_count_next;
              state_reg      <= S_DISCARD;
            end else if (!in_ctrl_nz) begin
              hdr_cnt_reg <= hdr_cnt_next;
              if (hdr_cnt_next == HDR_DONE)
                state_reg <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (in_wr) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_ONE;
            if (in_ctrl_nz) begin
              tail_ptr_reg  <= wr_ptr_reg;
              pkt_count_reg <= pkt_count_next;
              state_reg     <= mode ? S_HOLD : S_DRAIN;
            end else if (wr_ptr_reg == ADDR_TOP) begin
              drop_count_reg <= drop_count_next;
              state_reg      <= S_DISCARD;
            end
          end
        end
        S_DISCARD: begin
          if (in_wr && in_ctrl_nz) begin
            wr_ptr_reg  <= '0;
            hdr_cnt_reg <= '0;
            state_reg   <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (cpu_tail_we)
            tail_ptr_reg <= cpu_din[ADDR_WIDTH-1:0];
          // Send takes priority over drop when both command bits are set.
          if (cpu_cmd_we) begin
            if (cpu_din[0]) begin
              state_reg <= S_DRAIN;
            end else if (cpu_din[1]) begin
              drop_count_reg <= drop_count_next;
              wr_ptr_reg     <= '0;
              hdr_cnt_reg    <= '0;
              state_reg      <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (drain_issue) begin
            rd_ptr_reg <= rd_ptr_reg + ADDR_ONE;
            if (rd_ptr_reg == tail_ptr_reg)
              rd_done_reg <= 1'b1;
          end
          if (rd_valid_reg && rd_last_reg) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            hdr_cnt_reg <= '0;
            rd_done_reg <= 1'b0;
            state_reg   <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Egress read: a word issued in one cycle is presented with out_wr in the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      out_data_reg <= '0;
      out_ctrl_reg <= '0;
    end else begin
      rd_valid_reg <= drain_issue;
      rd_last_reg  <= drain_issue && (rd_ptr_reg == tail_ptr_reg);
      if (drain_issue) begin
        out_data_reg <= mem_data[rd_ptr_reg];
        out_ctrl_reg <= mem_ctrl[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_dout_reg <= '0;
    end else begin
      case (cpu_sel)
        SEL_DATA: cpu_dout_reg <= mem_data[cpu_addr];
        SEL_CTRL: cpu_dout_reg <= {{(DATA_WIDTH-CTRL_WIDTH){1'b0}}, mem_ctrl[cpu_addr]};
        default:  cpu_dout_reg <= status_word;
      endcase
    end
  end

  assign out_wr   = rd_valid_reg;
  assign out_data = out_data_reg;
  assign out_ctrl = out_ctrl_reg;
  assign cpu_dout = cpu_dout_reg;
  assign pkt_held = (state_reg == S_HOLD);

endmodule

// File: tb/tb_cvtb_pkt_buffer.sv
// Scoreboard bench for cvtb_pkt_buffer (16-word buffer): a packet-level model predicts
// forwarding, drops and counters; a monitor compares every egress word against the queue.
module tb_cvtb_pkt_buffer;

  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_wr = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy = 1'b1;
  logic          mode = 1'b0;
  logic [1:0]    cpu_sel = 2'b00;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic          cpu_wen = 1'b0;
  logic [DW-1:0] cpu_dout;
  logic          pkt_held;

  cvtb_pkt_buffer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_HDR_WORDS(3)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .mode(mode), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_wen(cpu_wen), .cpu_dout(cpu_dout), .pkt_held(pkt_held)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int n_out = 0;
  int rdy_mode = 0;
  int model_pkt = 0;
  int model_drop = 0;
  int model_tail = 0;
  logic [71:0] sb[$];
  logic [71:0] pkt[$];
  logic rdy_last = 1'b1;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] status_exp();
    logic [63:0] e;
    e = '0;
    e[63:48] = 16'(model_drop);
    e[47:32] = 16'(model_pkt);
    e[6:3]   = 4'(model_tail);
    return e;
  endfunction

  // Downstream readiness pattern: 0 always ready, 1 random, 2 alternating.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = ~out_rdy;
      endcase
    end
  end

  // Monitor: every out_wr must follow a ready cycle and match the scoreboard head.
  initial begin
    logic [71:0] exp;
    forever begin
      @(negedge clk);
      if (out_wr) begin
        n_out++;
        check("egress_slack", 72'(rdy_last), 72'(1));
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL egress_unexpected got=%h exp=none", {out_ctrl, out_data});
        end else begin
          exp = sb.pop_front();
          check("egress_word", {out_ctrl, out_data}, exp);
        end
      end
      rdy_last = out_rdy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cpu_read(input logic [1:0] sel, input int addr, input logic [63:0] exp, input string name);
    @(posedge clk); #1;
    cpu_sel = sel; cpu_addr = AW'(addr); cpu_wen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check(name, 72'(cpu_dout), 72'(exp));
  endtask

  task automatic cpu_write(input logic [1:0] sel, input int addr, input logic [63:0] din);
    @(posedge clk); #1;
    cpu_sel = sel; cpu_addr = AW'(addr); cpu_din = din; cpu_wen = 1'b1;
    @(posedge clk); #1;
    cpu_wen = 1'b0;
  endtask

  task automatic check_status(input string name);
    cpu_read(2'b10, 0, status_exp(), name);
  endtask

  task automatic build_pkt(input int k, input int m);
    pkt.delete();
    pkt.push_back({8'($urandom_range(1, 255)), rand64()});
    for (int i = 0; i < k; i++) pkt.push_back({8'($urandom_range(1, 255)), rand64()});
    for (int i = 0; i < 3 + m; i++) pkt.push_back({8'h00, rand64()});
    pkt.push_back({8'($urandom_range(1, 255)), rand64()});
  endtask

  task automatic send_pkt(input bit cap);
    for (int i = 0; i < pkt.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1; in_wr = 1'b0;
      end
      @(posedge clk); #1;
      in_wr = 1'b1; in_ctrl = pkt[i][71:64]; in_data = pkt[i][63:0]; mode = cap;
    end
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic wait_drain(input int n_exp);
    int base;
    int cyc;
    bit bad;
    base = n_out; cyc = 0; bad = 1'b0;
    while (n_out < base + n_exp && cyc < 2000) begin
      @(negedge clk); #1;
      cyc++;
      if (n_out < base + n_exp && in_rdy) bad = 1'b1;
    end
    check("drain_count", 72'(n_out - base), 72'(n_exp));
    check("drain_rdy_low", 72'(bad), 72'(0));
    check("rdy_low_at_last", 72'(in_rdy), 72'(0));
    @(negedge clk); #1;
    check("rdy_after_drain", 72'(in_rdy), 72'(1));
  endtask

  // Packet-level model: a packet longer than the buffer is dropped, otherwise counted.
  task automatic do_pkt(input bit cap, output bit held);
    int L;
    bit fwd;
    L = pkt.size();
    fwd = (L <= DEPTH);
    held = 1'b0;
    if (fwd && !cap) foreach (pkt[i]) sb.push_back(pkt[i]);
    send_pkt(cap);
    if (!fwd) begin
      model_drop++;
      @(negedge clk); #1;
      check("discard_rdy", 72'(in_rdy), 72'(1));
      check_status("discard_status");
    end else begin
      model_pkt++;
      model_tail = L - 1;
      if (cap) begin
        @(negedge clk); #1;
        check("held", 72'(pkt_held), 72'(1));
        check("held_rdy", 72'(in_rdy), 72'(0));
        held = 1'b1;
      end else begin
        wait_drain(L);
        check_status("pass_status");
      end
    end
  endtask

  task automatic handle_capture(input int act);
    int L;
    int a;
    int t;
    logic [71:0] w;
    logic [63:0] d;
    L = pkt.size();
    a = $urandom_range(0, L - 1);
    cpu_read(2'b00, a, pkt[a][63:0], "hold_rd_data");
    cpu_read(2'b01, a, 64'(pkt[a][71:64]), "hold_rd_ctrl");
    if (act == 0) begin
      cpu_write(2'b11, 0, 64'd2);
      model_drop++;
      @(negedge clk); #1;
      check("drop_rdy", 72'(in_rdy), 72'(1));
      check("drop_unheld", 72'(pkt_held), 72'(0));
      check_status("drop_status");
    end else begin
      d = rand64();
      w = pkt[a]; w[63:0] = d; pkt[a] = w;
      cpu_write(2'b00, a, d);
      if (act == 2) begin
        a = $urandom_range(0, L - 1);
        w = pkt[a]; w[71:64] = 8'($urandom_range(0, 255)); pkt[a] = w;
        cpu_write(2'b01, a, 64'(w[71:64]));
      end
      t = L - 1;
      if (act == 3) begin
        t = $urandom_range(L / 2, L - 1);
        cpu_write(2'b10, 0, 64'(t));
        model_tail = t;
      end
      for (int i = 0; i <= t; i++) sb.push_back(pkt[i]);
      cpu_write(2'b11, 0, ($urandom_range(0, 1) == 1) ? 64'd3 : 64'd1);
      wait_drain(t + 1);
      check_status("send_status");
    end
  endtask

  task automatic directed_pkt();
    logic [7:0] ctrls [7];
    ctrls = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    pkt.delete();
    for (int i = 0; i < 7; i++) pkt.push_back({ctrls[i], 64'(i + 1)});
  endtask

  initial begin
    bit held;
    int base;
    int cyc;
    logic [71:0] w;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_out_wr", 72'(out_wr), 72'(0));
    check("rst_in_rdy", 72'(in_rdy), 72'(1));
    check("rst_held", 72'(pkt_held), 72'(0));
    check("rst_cpu_dout", 72'(cpu_dout), 72'(0));
    check("rst_out_data", 72'(out_data), 72'(0));
    check_status("rst_status");

    // Directed pass-mode packet.
    directed_pkt();
    do_pkt(1'b0, held);

    // Writes and commands outside HOLD have no effect.
    cpu_write(2'b00, 0, 64'hBAD);
    cpu_write(2'b10, 0, 64'd9);
    cpu_write(2'b11, 0, 64'd1);
    repeat (4) @(posedge clk);
    cpu_read(2'b00, 0, 64'd1, "idle_wr_ignored");
    cpu_read(2'b01, 0, 64'hFF, "idle_ctrl_read");
    check_status("idle_cmd_ignored");

    // Capture, edit word 5, send.
    directed_pkt();
    do_pkt(1'b1, held);
    repeat (5) @(posedge clk);
    cpu_read(2'b00, 4, 64'd5, "cap_rd_addr4");
    cpu_read(2'b01, 6, 64'h80, "cap_rd_ctrl6");
    cpu_write(2'b00, 4, 64'hDEADBEEF);
    w = pkt[4]; w[63:0] = 64'hDEADBEEF; pkt[4] = w;
    foreach (pkt[i]) sb.push_back(pkt[i]);
    cpu_write(2'b11, 0, 64'd1);
    wait_drain(7);
    check_status("cap_send_status");

    // Capture then drop, followed by a normal pass packet.
    directed_pkt();
    do_pkt(1'b1, held);
    handle_capture(0);
    directed_pkt();
    do_pkt(1'b0, held);

    // Buffer boundaries: 20 words dropped, 16 forwarded, 17 dropped.
    build_pkt(0, 15); do_pkt(1'b0, held);
    build_pkt(0, 11); do_pkt(1'b0, held);
    build_pkt(0, 12); do_pkt(1'b0, held);

    // Alternating downstream readiness.
    rdy_mode = 2;
    directed_pkt(); do_pkt(1'b0, held);
    build_pkt(1, 6); do_pkt(1'b0, held);

    // Randomised packets, modes, CPU actions and backpressure.
    for (int p = 0; p < 30; p++) begin
      rdy_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        in_wr = 1'b1; in_ctrl = 8'h00; in_data = rand64();
        @(posedge clk); #1;
        in_wr = 1'b0;
      end
      build_pkt($urandom_range(0, 1), $urandom_range(0, 12));
      do_pkt(1'($urandom_range(0, 1)), held);
      if (held) handle_capture($urandom_range(0, 3));
    end

    // Reset during drain.
    rdy_mode = 0;
    directed_pkt();
    foreach (pkt[i]) sb.push_back(pkt[i]);
    base = n_out;
    send_pkt(1'b0);
    cyc = 0;
    while (n_out < base + 2 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("reset_pre_words", 72'(n_out - base), 72'(2));
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    model_pkt = 0; model_drop = 0; model_tail = 0;
    @(negedge clk); #1;
    check("reset_out_wr", 72'(out_wr), 72'(0));
    check("reset_in_rdy", 72'(in_rdy), 72'(1));
    check_status("reset_status");
    build_pkt(0, 4);
    do_pkt(1'b0, held);
    repeat (5) @(posedge clk);
    check("sb_empty", 72'(sb.size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
